risc_v_mc_control: RTL and testbench

//  Multicycle main controller for the RISC-V core. Sequences one shared ALU, register file and a unified

---
 rtl/risc_v_mc_control.sv | 254 +++++++++++++++++++++++++
 tb/tb_risc_v_mc_control.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mc_control.sv
// ---------------------------------------------------------------------------
// risc_v_mc_control
//   Multicycle main controller for the RISC-V core. It walks each instruction
//   through FETCH / DECODE / EXEC / MEM / WB steps. One ALU, one register file
//   and one unified instruction/data memory are shared across those steps.
//   Memory accesses use a req/ready handshake with an optional wait timeout.
//
// Optional feature macro: MC_CTRL_PERF_EN
//   When defined, the cycle_cnt and instret_cnt performance counter outputs
//   are added.
//
// Parameters
//   MEM_TIMEOUT  cycles mem_req may wait for mem_ready before trapping (0 = never)
//   CNT_W        performance counter width (MC_CTRL_PERF_EN only)
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   run                    execute enable, sampled in IDLE and at instruction end
//   opcode/func3/func7_b5  fields of the registered instruction
//   zero                   ALU zero flag
//   mem_ready              memory completes the requested access this cycle
//   mem_req, mem_we        memory request and write qualifier
//   adr_src                memory address select: 0 PC, 1 ALU result register
//   ir_write, pc_write     IR/oldPC load, PC load
//   reg_write              register file write enable
//   alu_src_a              00 PC, 01 oldPC, 10 rs1, 11 zero operand
//   alu_src_b              00 rs2, 01 imm, 10 constant 4
//   alu_op                 00 add, 01 sub, 10 func-decoded
//   result_src             00 ALU register, 01 memory data, 10 ALU direct
//   illegal                sticky: unknown opcode or bus timeout
//   state_o                current state encoding (debug)
//   cycle_cnt, instret_cnt performance counters (MC_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module risc_v_mc_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7_b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal,
`ifdef MC_CTRL_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_LUI    = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // The wait counter only needs to reach MEM_TIMEOUT-1. The cycle in which
    // it holds that value is the last allowed wait cycle.
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    logic             mem_expired;

    // The ALU ops of R/I instructions are decoded in the datapath, so func7_b5
    // is not needed here.
    logic unused_func7;
    assign unused_func7 = func7_b5;

    // A ready in the same cycle as the limit wins, so expiry requires !mem_ready.
    assign mem_expired = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)        state_d = S_DECODE;
                else if (mem_expired) state_d = S_TRAP;
                else                  tmo_d   = tmo_q + 1'b1;
            end
            S_DECODE: begin
                // The ALU forms the branch/jump target ahead of time.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready)        state_d = S_MEMWB;
                else if (mem_expired) state_d = S_TRAP;
                else                  tmo_d   = tmo_q + 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready)        retire  = 1'b1;
                else if (mem_expired) state_d = S_TRAP;
                else                  tmo_d   = tmo_q + 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                // rs1 - rs2 drives zero. The target computed in DECODE is in the ALU register.
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                if (func3 == 3'b000)      pc_write = zero;
                else if (func3 == 3'b001) pc_write = ~zero;
                retire = 1'b1;
            end
            S_JAL: begin
                // The PC takes the target from the ALU register while the ALU forms oldPC+4 as the link.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);
    assign illegal   = illegal_q;
    assign state_o   = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (retire) instret_cnt_q <= instret_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_risc_v_mc_control.sv
// ---------------------------------------------------------------------------
// tb_risc_v_mc_control
//   Scoreboard bench for the multicycle controller. The stimulus side walks
//   randomized instructions through the step sequence of each instruction
//   class. For every cycle it queues the expected output word. A monitor on the
//   falling edge pops each entry and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_risc_v_mc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  func3 = 3'd0;
    logic        func7_b5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0]  state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    risc_v_mc_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .func3      (func3),
        .func7_b5   (func7_b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .illegal    (illegal),
`ifdef MC_CTRL_PERF_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;
        int          cyc;
        int          ret;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;
    bit   in_idle = 1'b1;

    // Output word: state, req, we, adr, irw, pcw, rw, srcA, srcB, op, rsrc, illegal
    function automatic logic [18:0] mk(input logic [3:0] st, input logic req, input logic we,
                                       input logic adr, input logic irw, input logic pcw,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] rs, input logic ill);
        return {st, req, we, adr, irw, pcw, rw, a, b, op, rs, ill};
    endfunction

    function automatic logic [18:0] v_idle();   return mk(4'd0,  0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_fetch(input logic r);
                                                return mk(4'd1,  1,0,0,r,r,0, 2'b00,2'b10,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_decode(); return mk(4'd2,  0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_memadr(); return mk(4'd3,  0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_memrd();  return mk(4'd4,  1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_memwb();  return mk(4'd5,  0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0); endfunction
    function automatic logic [18:0] v_memwr();  return mk(4'd6,  1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_execr();  return mk(4'd7,  0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0); endfunction
    function automatic logic [18:0] v_execi();  return mk(4'd8,  0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0); endfunction
    function automatic logic [18:0] v_aluwb();  return mk(4'd9,  0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_branch(input logic t);
                                                return mk(4'd10, 0,0,0,0,t,0, 2'b10,2'b00,2'b01,2'b00, 0); endfunction
    function automatic logic [18:0] v_jal();    return mk(4'd11, 0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_lui();    return mk(4'd12, 0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0); endfunction
    function automatic logic [18:0] v_trap();   return mk(4'd15, 0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1); endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    exp_t        m_e;
    logic [18:0] m_act;
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            m_e   = sbq.pop_front();
            m_act = {state_o, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, result_src, illegal};
            checks++;
            if (m_act !== m_e.v) begin
                failures++;
                $display("FAIL %s: outputs got %b required %b", m_e.tag, m_act, m_e.v);
            end
`ifdef MC_CTRL_PERF_EN
            checks++;
            if (cycle_cnt !== 32'(m_e.cyc) || instret_cnt !== 32'(m_e.ret)) begin
                failures++;
                $display("FAIL %s_perf: cycle_cnt=%0d instret_cnt=%0d required %0d %0d",
                         m_e.tag, cycle_cnt, instret_cnt, m_e.cyc, m_e.ret);
            end
`endif
        end
    end

    // One clock cycle: drive inputs, queue this cycle's expected outputs, advance.
    task automatic cyc(input logic rdy, input logic zr, input logic rn,
                       input logic [18:0] v, input bit compl, input string tag);
        mem_ready = rdy;
        zero      = zr;
        run       = rn;
        sbq.push_back('{v, exp_cyc, exp_ret, tag});
        if (v[18:15] != 4'd0 && v[18:15] != 4'd15) exp_cyc++;
        if (compl) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n   = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        for (int i = 0; i < n; i++) cyc(rb(), rb(), 1'b0, v_idle(), 0, "reset");
        rst_n   = 1'b1;
        in_idle = 1'b1;
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 lui
    task automatic do_instr(input int kind, input int fw, input int dw, input logic zr,
                            input logic bne, input logic rafter);
        logic [6:0] ops [7];
        logic       taken;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110111;
        if (in_idle) cyc(rb(), rb(), 1'b1, v_idle(), 0, "idle_start");
        opcode   = ops[kind];
        func3    = (kind == 4) ? {2'b00, bne} : 3'($urandom_range(0, 7));
        func7_b5 = rb();
        for (int w = 0; w <= fw; w++) cyc(w == fw, rb(), rb(), v_fetch(w == fw), 0, "fetch");
        cyc(rb(), rb(), rb(), v_decode(), 0, "decode");
        case (kind)
            0: begin
                cyc(rb(), rb(), rb(), v_memadr(), 0, "lw_adr");
                for (int w = 0; w <= dw; w++) cyc(w == dw, rb(), rb(), v_memrd(), 0, "lw_rd");
                cyc(rb(), rb(), rafter, v_memwb(), 1, "lw_wb");
            end
            1: begin
                cyc(rb(), rb(), rb(), v_memadr(), 0, "sw_adr");
                for (int w = 0; w < dw; w++) cyc(1'b0, rb(), rb(), v_memwr(), 0, "sw_wait");
                cyc(1'b1, rb(), rafter, v_memwr(), 1, "sw_wr");
            end
            2: begin
                cyc(rb(), rb(), rb(), v_execr(), 0, "r_exec");
                cyc(rb(), rb(), rafter, v_aluwb(), 1, "r_wb");
            end
            3: begin
                cyc(rb(), rb(), rb(), v_execi(), 0, "i_exec");
                cyc(rb(), rb(), rafter, v_aluwb(), 1, "i_wb");
            end
            4: begin
                taken = bne ? !zr : zr;
                cyc(rb(), zr, rafter, v_branch(taken), 1, bne ? "bne" : "beq");
            end
            5: begin
                cyc(rb(), rb(), rb(), v_jal(), 0, "jal");
                cyc(rb(), rb(), rafter, v_aluwb(), 1, "jal_wb");
            end
            default: begin
                cyc(rb(), rb(), rb(), v_lui(), 0, "lui");
                cyc(rb(), rb(), rafter, v_aluwb(), 1, "lui_wb");
            end
        endcase
        in_idle = !rafter;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);
        // Idle with run low: nothing moves for 10 cycles.
        for (int i = 0; i < 10; i++) cyc(rb(), rb(), 1'b0, v_idle(), 0, "idle");

        // Three back-to-back zero-wait R-types, then stop: 12 active cycles, 3 retired.
        do_instr(2, 0, 0, 1'b0, 1'b0, 1'b1);
        do_instr(2, 0, 0, 1'b0, 1'b0, 1'b1);
        do_instr(2, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(rb(), rb(), 1'b0, v_idle(), 0, "perf_idle");

        // lw with 3 data wait cycles (the ready lands on the last allowed cycle).
        do_instr(0, 0, 3, 1'b0, 1'b0, 1'b1);
        // beq / bne with both zero values.
        do_instr(4, 0, 0, 1'b1, 1'b0, 1'b1);
        do_instr(4, 0, 0, 1'b0, 1'b0, 1'b1);
        do_instr(4, 0, 0, 1'b1, 1'b1, 1'b1);
        do_instr(4, 0, 0, 1'b0, 1'b1, 1'b0);

        // Randomized instruction mix.
        for (int n = 0; n < 40; n++)
            do_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                     rb(), rb(), ($urandom_range(0, 3) != 0));

        // Unknown opcode: TRAP is sticky whatever run does.
        if (in_idle) cyc(rb(), rb(), 1'b1, v_idle(), 0, "idle_start");
        opcode = 7'b1111111;
        cyc(1'b1, rb(), rb(), v_fetch(1'b1), 0, "fetch");
        cyc(rb(), rb(), rb(), v_decode(), 0, "decode_bad");
        for (int i = 0; i < 5; i++) cyc(rb(), rb(), 1'b1, v_trap(), 0, "trap_sticky");
        do_reset(2);

        // Fetch timeout: 4 cycles without ready, then TRAP.
        cyc(1'b0, rb(), 1'b1, v_idle(), 0, "idle_start");
        for (int i = 0; i < 4; i++) cyc(1'b0, rb(), rb(), v_fetch(1'b0), 0, "fetch_tmo");
        for (int i = 0; i < 3; i++) cyc(rb(), rb(), rb(), v_trap(), 0, "trap_tmo");
        do_reset(2);

        // Data read timeout.
        cyc(1'b0, rb(), 1'b1, v_idle(), 0, "idle_start");
        opcode = 7'b0000011;
        cyc(1'b1, rb(), rb(), v_fetch(1'b1), 0, "fetch");
        cyc(rb(), rb(), rb(), v_decode(), 0, "decode");
        cyc(rb(), rb(), rb(), v_memadr(), 0, "lw_adr");
        for (int i = 0; i < 4; i++) cyc(1'b0, rb(), rb(), v_memrd(), 0, "lw_tmo");
        cyc(rb(), rb(), rb(), v_trap(), 0, "trap_dtmo");
        do_reset(2);

        // Reset during a pending fetch drops mem_req at once.
        cyc(1'b0, rb(), 1'b1, v_idle(), 0, "idle_start");
        cyc(1'b0, rb(), 1'b1, v_fetch(1'b0), 0, "fetch_pre_rst");
        rst_n   = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        cyc(1'b0, rb(), 1'b1, v_idle(), 0, "rst_abort");
        rst_n   = 1'b1;
        in_idle = 1'b1;
        do_instr(6, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(rb(), rb(), 1'b0, v_idle(), 0, "final_idle");

        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
